router_fsm: RTL
===============

Name: router_fsm

Overview:
Packet-ingress controller for the 1x3 router. It sequences each incoming packet through header decode, first-byte load, payload load, FIFO-full stall and parity handling. It generates the control strobes that the register block and the synchronizer consume: detect_add, write_enb_reg, the load-phase flags and busy. It sits between the input port and the synchronizer/register blocks and is the only source of the packet-level write sequencing.

Parameters:
ADDR_INVALID, 2'b11, destination code that is never accepted; the header is ignored and the FSM stays in DECODE_ADDRESS.

Ports:
clock  input  1  system clock, all state updates on the rising edge
resetn  input  1  synchronous active-low reset
pkt_valid  input  1  high while header/payload bytes are presented; its falling edge marks the parity byte
data_in  input  2  destination address field (bits [1:0] of the header byte)
fifo_full  input  1  full flag of the currently selected output FIFO (from the synchronizer)
fifo_empty_0  input  1  empty flag, output FIFO 0
fifo_empty_1  input  1  empty flag, output FIFO 1
fifo_empty_2  input  1  empty flag, output FIFO 2
soft_reset_0  input  1  timeout soft reset, port 0
soft_reset_1  input  1  timeout soft reset, port 1
soft_reset_2  input  1  timeout soft reset, port 2
parity_done  input  1  register block has captured the parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while a stall was in progress
detect_add  output  1  high in DECODE_ADDRESS
lfd_state  output  1  high in LOAD_FIRST_DATA
ld_state  output  1  high in LOAD_DATA
laf_state  output  1  high in LOAD_AFTER_FULL
full_state  output  1  high in FIFO_FULL_STATE
write_enb_reg  output  1  FIFO write permitted
rst_int_reg  output  1  high in CHECK_PARITY_ERROR
busy  output  1  source must hold its current byte

Behaviour:
- One clock domain. Reset is synchronous and active-low: when resetn=0 at a rising edge, the state becomes DECODE_ADDRESS and addr_q becomes 2'b00.
- addr_q is a 2-bit register. It captures data_in on the edge where the FSM is in DECODE_ADDRESS with pkt_valid=1 and data_in!=ADDR_INVALID. It is held in every other case.
- Outputs are Moore outputs, decoded combinationally from the registered state. After reset: detect_add=1 and all other outputs are 0.
- Output decode:
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- State transitions (evaluated at each rising edge):
  - DECODE_ADDRESS:
    - pkt_valid=1, data_in!=11, fifo_empty_[data_in]=1 -> LOAD_FIRST_DATA.
    - pkt_valid=1, data_in!=11, fifo_empty_[data_in]=0 -> WAIT_TILL_EMPTY.
    - Otherwise stay. An invalid address produces no write.
  - WAIT_TILL_EMPTY: fifo_empty_[addr_q]=1 -> LOAD_FIRST_DATA; else stay.
  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally. The header is written exactly one cycle after the state is entered.
  - LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else if pkt_valid=0 -> LOAD_PARITY; else stay. fifo_full takes priority when both conditions hold.
  - FIFO_FULL_STATE: fifo_full=0 -> LOAD_AFTER_FULL; else stay.
  - LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else if low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
  - CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Soft reset:
  - In any state other than DECODE_ADDRESS, soft_reset_[addr_q]=1 forces the next state to DECODE_ADDRESS. This overrides every transition above.
  - Soft resets on non-selected ports are ignored.
  - resetn has priority over soft reset.
- State encoding: 3 bits, binary, all 8 codes used, no illegal states.
- Latency from an accepted header (pkt_valid=1 in DECODE_ADDRESS, target FIFO empty) to the first write_enb_reg: 2 cycles.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> detect_add=1, busy=0, write_enb_reg=0. Release -> the FSM stays in DECODE_ADDRESS while pkt_valid=0.
- Nominal packet to port 1: data_in=01, pkt_valid=1, fifo_empty_1=1, 4 payload cycles, then pkt_valid=0.
  - Expected state sequence: DECODE_ADDRESS -> LOAD_FIRST_DATA (busy=1) -> 4x LOAD_DATA (write_enb_reg=1, busy=0) -> LOAD_PARITY -> CHECK_PARITY_ERROR (rst_int_reg=1) -> DECODE_ADDRESS.
- Busy destination: data_in=10, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY is held with busy=1. Raise fifo_empty_2 -> LOAD_FIRST_DATA on the next edge.
- Stall: in LOAD_DATA, raise fifo_full for 3 cycles -> FIFO_FULL_STATE with full_state=1, write_enb_reg=0. Drop fifo_full -> LOAD_AFTER_FULL.
  - With low_pkt_valid=0 the next state is LOAD_DATA.
  - Repeat with low_pkt_valid=1 -> LOAD_PARITY.
  - Repeat with parity_done=1 -> DECODE_ADDRESS.
- Invalid address and soft reset:
  - data_in=11 with pkt_valid=1 -> the FSM stays in DECODE_ADDRESS and write_enb_reg never asserts.
  - In FIFO_FULL_STATE with addr_q=00, assert soft_reset_0 for 1 cycle -> DECODE_ADDRESS on the next edge.
  - soft_reset_1 in the same situation -> no effect.

Source files
------------

// File: rtl/router_fsm_if.sv
// Ingress-side signal bundle between the input port/register block and the router FSM.
// The master drives packet and FIFO status; the slave (the FSM) returns the load-phase strobes.
interface router_fsm_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output pkt_valid, data_in, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output soft_reset_0, soft_reset_1, soft_reset_2,
        output parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state,
        input  write_enb_reg, rst_int_reg, busy
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  soft_reset_0, soft_reset_1, soft_reset_2,
        input  parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state,
        output write_enb_reg, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// Packet-ingress sequencer for the 1x3 router: decode, first-byte, payload, stall and parity phases.
// Latency: first write_enb_reg two cycles after an accepted header; all outputs are Moore decodes.
// Backpressure: busy holds the source in every state except DECODE_ADDRESS and LOAD_DATA.
module router_fsm #(
    parameter logic [1:0] ADDR_INVALID = 2'b11
) (
    input  logic         clock,
    input  logic         resetn,
    router_fsm_if.slave  bus
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [1:0] addr_q;
    logic       hdr_ok;
    logic       empty_in;
    logic       empty_sel;
    logic       soft_sel;

    assign hdr_ok = bus.pkt_valid && (bus.data_in != ADDR_INVALID);

    // Header decode looks at the live address; later phases use the captured one.
    always_comb begin
        empty_in = 1'b0;
        case (bus.data_in)
            2'b00:   empty_in = bus.fifo_empty_0;
            2'b01:   empty_in = bus.fifo_empty_1;
            2'b10:   empty_in = bus.fifo_empty_2;
            default: empty_in = 1'b0;
        endcase
    end

    always_comb begin
        empty_sel = 1'b0;
        soft_sel  = 1'b0;
        case (addr_q)
            2'b00: begin
                empty_sel = bus.fifo_empty_0;
                soft_sel  = bus.soft_reset_0;
            end
            2'b01: begin
                empty_sel = bus.fifo_empty_1;
                soft_sel  = bus.soft_reset_1;
            end
            2'b10: begin
                empty_sel = bus.fifo_empty_2;
                soft_sel  = bus.soft_reset_2;
            end
            default: begin
                empty_sel = 1'b0;
                soft_sel  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= DECODE_ADDRESS;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q <= 2'b00;
        end else if (state == DECODE_ADDRESS && hdr_ok) begin
            addr_q <= bus.data_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    next_state = empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) begin
                    next_state = LOAD_FIRST_DATA;
                end
            end
            LOAD_FIRST_DATA: next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (bus.fifo_full) begin
                    next_state = FIFO_FULL_STATE;
                end else if (!bus.pkt_valid) begin
                    next_state = LOAD_PARITY;
                end
            end
            FIFO_FULL_STATE: begin
                if (!bus.fifo_full) begin
                    next_state = LOAD_AFTER_FULL;
                end
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done) begin
                    next_state = DECODE_ADDRESS;
                end else if (bus.low_pkt_valid) begin
                    next_state = LOAD_PARITY;
                end else begin
                    next_state = LOAD_DATA;
                end
            end
            LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                next_state = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: next_state = DECODE_ADDRESS;
        endcase

        // A timeout on the port we are feeding abandons the packet from any phase.
        if (state != DECODE_ADDRESS && soft_sel) begin
            next_state = DECODE_ADDRESS;
        end
    end

    always_comb begin
        bus.detect_add    = (state == DECODE_ADDRESS);
        bus.lfd_state     = (state == LOAD_FIRST_DATA);
        bus.ld_state      = (state == LOAD_DATA);
        bus.laf_state     = (state == LOAD_AFTER_FULL);
        bus.full_state    = (state == FIFO_FULL_STATE);
        bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
        bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                            (state == LOAD_AFTER_FULL);
        bus.busy          = (state != DECODE_ADDRESS) && (state != LOAD_DATA);
    end

endmodule
